adc_event_packer: RTL and testbench
===================================

Name: adc_event_packer

Overview:
Downstream consumer of the 16 deserialized 12-bit ADC channels (CH0..CH15) out of the ADC unit. On a trigger it snapshots all 16 channels in one clk cycle. It then streams the snapshot as a framed sequence of 16-bit words (header, channel words, trailer) over a valid/ready interface to the readout logic. Triggers are accepted only while the ADC unit reports configuration done and deserializers running.

Parameters:
- NCH, 16, number of channels packed (fixed 16 in this revision; 4-bit channel index)
- HDR_TAG, 4'hA, upper nibble of header word
- TRL_TAG, 4'hF, upper nibble of trailer word

Ports:
- clk  in  1  ADC sample clock, same clk that drives the ADC unit
- rst  in  1  synchronous reset, active-high
- ch_data  in  192  CHn at [12n+11:12n], n=0..15, valid every clk
- conf_end  in  1  ADC configuration finished
- des_run  in  1  deserializers locked/running
- trig  in  1  capture request, single-cycle pulse or level (rising edge used)
- out_data  out  16  packed word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid&out_ready
- busy  out  1  high from capture until trailer accepted
- event_cnt  out  12  events packed, wraps 4095->0
- drop_cnt  out  12  triggers lost while busy/not armed, saturates at 4095

Behaviour:
- Reset: out_data=0, out_valid=0, busy=0, event_cnt=0, drop_cnt=0, FSM=IDLE, trig edge register=0.
- armed = conf_end & des_run. trig_rise = trig & ~trig_d (trig_d registered each clk).
- FSM states: IDLE, HDR, DATA, TRL.
- IDLE: on trig_rise & armed -> latch ch_data into 192-bit snapshot same edge, busy=1, next HDR. On trig_rise & ~armed -> drop_cnt++ (saturating), stay IDLE.
- HDR: out_valid=1, out_data={HDR_TAG, event_cnt}. On handshake -> DATA, idx=0.
- DATA: out_data={idx[3:0], snap[12*idx+:12]}, out_valid=1. Handshake with idx=15 -> TRL, else idx++.
- TRL: out_data={TRL_TAG, drop_cnt}. On handshake -> IDLE, busy=0, event_cnt++ (wrap).
- Latency: trig_rise at cycle t -> first header word valid at t+1. With out_ready held 1: 18 words in cycles t+1..t+18; busy falls at t+19.
- out_data/out_valid registered; out_data stable while out_valid&~out_ready (AXI-stream rule, no retraction).
- trig_rise in any state other than IDLE -> drop_cnt++ (saturating); snapshot not altered.
- Trigger edge in same cycle as trailer handshake: counted as dropped (FSM still leaving TRL).
- Trailer reports drop_cnt value at time of TRL entry.
- armed falling mid-frame: frame completes normally (snapshot already held).
- rst mid-frame: abort immediately to reset values, no trailer emitted.

Optional Feature:
- ADC_CHMASK_EN: adds input ch_mask [15:0], sampled with snapshot at capture. DATA emits only channels with mask bit=1, ascending order. Header bits [11:0] become {popcount[4:0] of mask, event_cnt[6:0]}. Mask=0 -> HDR goes directly to TRL.
- Without the macro: all 16 channels always emitted; header as above.

Decomposition:
- Package adc_pkg: NCH, ADC_W=12, WORD_W=16, HDR_TAG/TRL_TAG defaults, FSM state enum, word-builder constants.
- One sub-module natural: adc_snapshot_reg (192-bit capture register plus 12-bit channel select mux by idx). FSM and counters stay in the top.

Test Plan:
- Armed, out_ready=1, ch_data CHn=12'h100+n, trig pulse -> words A000, 0100,1101,...,F10F, F000 in 18 consecutive cycles; event_cnt=1.
- conf_end=0, 3 trig pulses -> no output, drop_cnt=3, event_cnt=0.
- out_ready toggled 1/0 each cycle during frame -> out_data held stable while stalled, 18 words in order, no duplicates or loss.
- Second trig rise during DATA idx=5 -> frame unchanged, trailer reads F001, drop_cnt=1.
- Change ch_data every cycle after capture -> emitted values equal those at trigger cycle only.
- rst asserted at DATA idx=8 -> out_valid=0 next cycle, counters 0; fresh trig produces full frame with header A000.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg -- shared constants, FSM state type and helper functions for the
// ADC event packer.
//
// Contents:
//   NCH, ADC_W, WORD_W, IDX_W, CNT_W   geometry of the snapshot and word stream
//   HDR_TAG_DEF / TRL_TAG_DEF          default tag nibbles for header/trailer
//   state_t                            packer FSM states
//   popcount()                         set-bit count of a channel mask
//   next_ch()                          lowest enabled channel at or above a start index
package adc_pkg;

  localparam int NCH    = 16;  // channels per snapshot
  localparam int ADC_W  = 12;  // bits per channel sample
  localparam int WORD_W = 16;  // output word width
  localparam int IDX_W  = 4;   // channel index width
  localparam int CNT_W  = 12;  // event / drop counter width

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;
  localparam logic [3:0] TRL_TAG_DEF = 4'hF;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_TRL  = 2'd3
  } state_t;

  // Number of enabled channels; 5 bits so that a full mask (16) fits.
  function automatic logic [4:0] popcount(input logic [NCH-1:0] mask);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + 5'(mask[i]);
    end
    return n;
  endfunction

  // Lowest channel index >= start whose mask bit is set. Bit 4 of the result
  // is set (value 16) when no such channel exists, which ends the data phase.
  function automatic logic [4:0] next_ch(input logic [NCH-1:0] mask,
                                         input logic [4:0]     start);
    logic [4:0] r;
    r = 5'd16;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= start)) begin
        r = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_event_packer_if.sv
// adc_event_packer_if -- valid/ready word stream from the packer to readout.
//
// Signals:
//   out_data   [15:0]  packed word (header, channel word or trailer)
//   out_valid          out_data holds a word
//   out_ready          consumer accepts the word when out_valid & out_ready
// Modports:
//   master  driven by the packer
//   slave   used by the readout logic / testbench
interface adc_event_packer_if;
  import adc_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/adc_snapshot_reg.sv
// adc_snapshot_reg -- 16 x 12-bit capture register with a channel read mux.
//
// Ports:
//   clk       sample clock
//   rst       synchronous active-high reset, clears the snapshot
//   capture   load all channels from ch_data on this clock edge
//   ch_data   [191:0] live channels, CHn at [12n+11:12n]
//   sel       [3:0]   channel to present on sel_data
//   sel_data  [11:0]  snapshot value of channel sel (combinational)
module adc_snapshot_reg
  import adc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [NCH*ADC_W-1:0]   ch_data,
  input  logic [IDX_W-1:0]       sel,
  output logic [ADC_W-1:0]       sel_data
);

  logic [ADC_W-1:0] ch_in [NCH];
  logic [ADC_W-1:0] snap  [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
      assign ch_in[gi] = ch_data[gi*ADC_W +: ADC_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        snap[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NCH; i++) begin
        snap[i] <= ch_in[i];
      end
    end
  end

  // The mux is combinational so the top can register the selected word in
  // the same cycle it advances the channel index.
  assign sel_data = snap[sel];

endmodule

// File: rtl/adc_event_packer.sv
// adc_event_packer -- snapshots 16 ADC channels on a trigger edge and streams
// them as a framed word sequence: header, channel words, trailer.
//
// Ports:
//   clk        ADC sample clock
//   rst        synchronous active-high reset (aborts any frame in flight)
//   ch_data    [191:0] live channels, CHn at [12n+11:12n]
//   conf_end   ADC configuration finished
//   des_run    deserializers running
//   trig       capture request; only its rising edge matters
//   ch_mask    [15:0] channel enable mask (only with ADC_CHMASK_EN)
//   out_if     master side of the valid/ready word stream
//   busy       high from capture until the trailer is accepted
//   event_cnt  [11:0] frames completed, wraps
//   drop_cnt   [11:0] triggers ignored (busy or not armed), saturates
//
// Word formats:
//   header   {HDR_TAG, event_cnt}
//            with ADC_CHMASK_EN: {HDR_TAG, popcount(mask), event_cnt[6:0]}
//   channel  {channel index, 12-bit sample}
//   trailer  {TRL_TAG, drop_cnt as seen when the trailer is loaded}
//
// Build option: define ADC_CHMASK_EN to add ch_mask; only enabled channels
// are emitted, in ascending order, and an all-zero mask goes header->trailer.
module adc_event_packer
  import adc_pkg::*;
#(
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEF,
  parameter logic [3:0] TRL_TAG = TRL_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*ADC_W-1:0] ch_data,
  input  logic                 conf_end,
  input  logic                 des_run,
  input  logic                 trig,
`ifdef ADC_CHMASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  adc_event_packer_if.master   out_if,
  output logic                 busy,
  output logic [CNT_W-1:0]     event_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              trig_d;

  logic              armed;
  logic              trig_rise;
  logic              capture;
  logic              handshake;
  logic [NCH-1:0]    mask;
  logic [4:0]        scan_from;
  logic [4:0]        nxt;
  logic [ADC_W-1:0]  sel_data;
  logic [WORD_W-1:0] hdr_word;

  assign armed     = conf_end & des_run;
  assign trig_rise = trig & ~trig_d;
  assign capture   = (state == S_IDLE) && trig_rise && armed;
  assign handshake = out_valid & out_if.out_ready;

`ifdef ADC_CHMASK_EN
  // Mask is frozen together with the snapshot so a frame is self-consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
    end else if (capture) begin
      mask <= ch_mask;
    end
  end
  assign hdr_word = {HDR_TAG, popcount(ch_mask), event_cnt[6:0]};
`else
  assign mask     = '1;
  assign hdr_word = {HDR_TAG, event_cnt};
`endif

  // From the header the scan starts at channel 0; in the data phase it starts
  // just past the channel currently on the bus. idx=15 gives 16, i.e. done.
  assign scan_from = (state == S_DATA) ? ({1'b0, idx} + 5'd1) : 5'd0;
  assign nxt       = next_ch(mask, scan_from);

  adc_snapshot_reg u_snap (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .ch_data  (ch_data),
    .sel      (nxt[IDX_W-1:0]),
    .sel_data (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      event_cnt <= '0;
      drop_cnt  <= '0;
      trig_d    <= 1'b0;
    end else begin
      trig_d <= trig;

      // Any edge that does not start a frame is a drop, including one that
      // coincides with the trailer handshake (the FSM is still in TRL).
      if (trig_rise && !capture && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (capture) begin
            state     <= S_HDR;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= hdr_word;
          end
        end

        S_HDR, S_DATA: begin
          if (handshake) begin
            if (nxt[4]) begin
              state    <= S_TRL;
              out_data <= {TRL_TAG, drop_cnt};
            end else begin
              state    <= S_DATA;
              idx      <= nxt[IDX_W-1:0];
              out_data <= {nxt[IDX_W-1:0], sel_data};
            end
          end
        end

        S_TRL: begin
          if (handshake) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            event_cnt <= event_cnt + 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_data  = out_data;
  assign out_if.out_valid = out_valid;

endmodule

// File: tb/tb_adc_event_packer.sv
// tb_adc_event_packer -- self-checking bench for adc_event_packer (default
// build). A frame-level model turns every accepted trigger into the list of
// words the stream must carry; a negedge process compares the DUT with it.
module tb_adc_event_packer;
  import adc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH*ADC_W-1:0] ch_data = '0;
  logic                 conf_end = 1'b0;
  logic                 des_run = 1'b0;
  logic                 trig = 1'b0;
  logic                 busy;
  logic [CNT_W-1:0]     event_cnt;
  logic [CNT_W-1:0]     drop_cnt;
`ifdef ADC_CHMASK_EN
  logic [NCH-1:0]       ch_mask = '1;
`endif

  adc_event_packer_if out_if ();

  always #5 clk = ~clk;

  adc_event_packer dut (
    .clk       (clk),
    .rst       (rst),
    .ch_data   (ch_data),
    .conf_end  (conf_end),
    .des_run   (des_run),
    .trig      (trig),
`ifdef ADC_CHMASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_if    (out_if),
    .busy      (busy),
    .event_cnt (event_cnt),
    .drop_cnt  (drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] q[$];        // words still owed on the stream, front = on bus
  logic [15:0] dut_log[$];  // words the DUT actually handed over
  bit          m_busy, m_trig_d, started;
  int          m_evt, m_drop, m_sent;
  bit          pre_busy, rise;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_busy = 0; m_trig_d = 0; m_evt = 0; m_drop = 0; m_sent = 0;
      started = 1;
    end else if (started) begin
      pre_busy = m_busy;
      rise     = trig && !m_trig_d;
      m_trig_d = trig;
      if (q.size() > 0 && out_if.out_ready) begin
        void'(q.pop_front());
        m_sent++;
        if (m_sent == 17) q.push_back({4'hF, 12'(m_drop)});  // after CH15
        if (m_sent == 18) begin
          m_busy = 0;
          m_evt  = (m_evt + 1) % 4096;
          m_sent = 0;
        end
      end
      if (rise) begin
        if (!pre_busy && conf_end && des_run) begin
          m_busy = 1;
          q.push_back({4'hA, 12'(m_evt)});
          for (int n = 0; n < 16; n++) q.push_back({4'(n), ch_data[12*n +: 12]});
        end else if (m_drop < 4095) begin
          m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_if.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("out_data", 32'(out_if.out_data), 32'(q[0]));
      check("busy", 32'(busy), 32'(m_busy));
      check("event_cnt", 32'(event_cnt), 32'(m_evt));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (out_if.out_valid && out_if.out_ready) dut_log.push_back(out_if.out_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1; tick(2); rst = 0;
    dut_log.delete();
  endtask

  task automatic pulse();
    trig = 1; tick(1); trig = 0;
  endtask

  task automatic set_ramp();
    for (int n = 0; n < 16; n++) ch_data[12*n +: 12] = 12'h100 + 12'(n);
  endtask

  task automatic rand_data();
    ch_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Hand-computed frame for the ramp pattern with event 0.
  task automatic check_ramp_frame(input string tag, input logic [11:0] drops);
    check({tag, "_len"}, 32'(dut_log.size()), 32'd18);
    if (dut_log.size() == 18) begin
      check({tag, "_hdr"}, 32'(dut_log[0]), 32'h0000A000);
      for (int n = 0; n < 16; n++)
        check({tag, "_ch"}, 32'(dut_log[1+n]), 32'h0100 + 32'(n) * 32'h1001);
      check({tag, "_trl"}, 32'(dut_log[17]), {20'h0, 4'hF, drops});
    end
  endtask

  initial begin
    out_if.out_ready = 1'b1;
    tick(1);
    do_reset();
    conf_end = 1; des_run = 1;

    // Basic frame, ready always high.
    set_ramp();
    pulse();
    tick(24);
    check_ramp_frame("basic", 12'h000);
    check("basic_evt", 32'(event_cnt), 32'd1);

    // Not armed: three dropped triggers.
    do_reset();
    conf_end = 0;
    repeat (3) begin pulse(); tick(1); end
    tick(3);
    check("unarmed_len", 32'(dut_log.size()), 32'd0);
    check("unarmed_drop", 32'(drop_cnt), 32'd3);
    check("unarmed_evt", 32'(event_cnt), 32'd0);
    conf_end = 1;

    // Ready toggling every cycle.
    do_reset();
    set_ramp();
    pulse();
    for (int i = 0; i < 45; i++) begin
      out_if.out_ready = ~out_if.out_ready;
      tick(1);
    end
    out_if.out_ready = 1;
    tick(4);
    check_ramp_frame("stall", 12'h000);

    // Second trigger during the data phase, plus ch_data scrambled after capture.
    do_reset();
    set_ramp();
    pulse();
    rand_data();
    tick(6);
    rand_data();
    pulse();
    for (int i = 0; i < 20; i++) begin rand_data(); tick(1); end
    check_ramp_frame("retrig", 12'h001);
    check("retrig_drop", 32'(drop_cnt), 32'd1);

    // Reset in the middle of the data phase.
    do_reset();
    set_ramp();
    pulse();
    tick(9);
    rst = 1; tick(1); rst = 0;
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_evt", 32'(event_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    dut_log.delete();
    pulse();
    tick(22);
    check_ramp_frame("after_rst", 12'h000);

    // Level trigger: a single frame for one long high pulse.
    do_reset();
    trig = 1; tick(30); trig = 0; tick(2);
    check("level_evt", 32'(event_cnt), 32'd1);
    check("level_drop", 32'(drop_cnt), 32'd0);

    // Drop counter saturation.
    do_reset();
    conf_end = 0;
    for (int i = 0; i < 4100; i++) begin pulse(); tick(1); end
    check("drop_sat", 32'(drop_cnt), 32'd4095);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rand_data();
      trig             = ($urandom_range(0, 99) < 8);
      out_if.out_ready = ($urandom_range(0, 99) < 70);
      conf_end         = ($urandom_range(0, 99) < 92);
      des_run          = ($urandom_range(0, 99) < 95);
      rst              = ($urandom_range(0, 999) < 2);
      tick(1);
    end
    rst = 0; trig = 0; out_if.out_ready = 1;
    tick(25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
